// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller:
// operand-forward selects and the divider sequencer states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/hazard_div_fsm.sv
// Multi-cycle divider sequencer: launch pulse, busy countdown
// and a single non-stalling DONE cycle for result capture.
module hazard_div_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_e,
  input  logic exc_m,
  output logic div_start,
  output logic div_busy,
  output logic div_stall
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          launch;

  assign launch = (state_q == IDLE) & div_e & ~exc_m & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (exc_m) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    div_start = launch;
    div_busy  = launch | (state_q == BUSY);
    div_stall = div_busy;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline with
// multi-cycle divider interlock and exception flush priority.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGW       = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregD,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            jumprD,
  input  logic [4:0]      rdE,
  input  logic [4:0]      rdM,
  input  logic            cp0writeM,
  input  logic            divE,
  input  logic            excM,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            forwardcp0dataE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            div_start,
  output logic            div_busy
);

  logic div_stall;
  logic lwstall;
  logic brstall;
  logic e_hits_d;
  logic m_hits_d;

  hazard_div_fsm #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_fsm (
    .clk       (clk),
    .rst       (rst),
    .div_e     (divE),
    .exc_m     (excM),
    .div_start (div_start),
    .div_busy  (div_busy),
    .div_stall (div_stall)
  );

  always_comb begin
    forwardAE = FWD_RF;
    if ((rsE != '0) && regwriteM && (rsE == writeregM))
      forwardAE = FWD_M;
    else if ((rsE != '0) && regwriteW && (rsE == writeregW))
      forwardAE = FWD_W;
  end

  always_comb begin
    forwardBE = FWD_RF;
    if ((rtE != '0) && regwriteM && (rtE == writeregM))
      forwardBE = FWD_M;
    else if ((rtE != '0) && regwriteW && (rtE == writeregW))
      forwardBE = FWD_W;
  end

  assign forwardAD = (rsD != '0) & regwriteM & (rsD == writeregM);
  assign forwardBD = (rtD != '0) & regwriteM & (rtD == writeregM);

  assign forwardcp0dataE = cp0writeM & (rdE == rdM);

  assign lwstall = memtoregE & ~memtoregD & (rtE != '0)
                 & ((rsD == rtE) | (rtD == rtE));

  assign e_hits_d = regwriteE & (writeregE != '0)
                  & ((writeregE == rsD) | (writeregE == rtD));
  // ALU results in M reach D by forwarding; only loads interlock.
  assign m_hits_d = memtoregM & (writeregM != '0)
                  & ((writeregM == rsD) | (writeregM == rtD));
  assign brstall  = (branchD | jumprD) & (e_hits_d | m_hits_d);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (excM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (div_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwstall | brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a 4-cycle
// divider; stimulus on negedge, outputs sampled 1ns later.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregD, memtoregE, memtoregM;
  logic       branchD, jumprD;
  logic [4:0] rdE, rdM;
  logic       cp0writeM, divE, excM;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, forwardcp0dataE;
  logic       stallF, stallD, stallE;
  logic       flushD, flushE, flushM;
  logic       div_start, div_busy;
  logic [14:0] outs;

  int vec  = 0;
  int errs = 0;

  // {fAE, fBE, fAD, fBD, fcp0, sF, sD, sE, fD, fE, fM, start, busy}
  localparam logic [14:0] O_ZERO = 15'b00_00_0_0_0_000_000_00;
  localparam logic [14:0] O_LNCH = 15'b00_00_0_0_0_111_001_11;
  localparam logic [14:0] O_BUSY = 15'b00_00_0_0_0_111_001_01;
  localparam logic [14:0] O_EXC  = 15'b00_00_0_0_0_000_111_00;
  localparam logic [14:0] O_EXCB = 15'b00_00_0_0_0_000_111_01;
  localparam logic [14:0] O_LWST = 15'b00_00_0_0_0_110_010_00;

  assign outs = {forwardAE, forwardBE, forwardAD, forwardBD,
                 forwardcp0dataE, stallF, stallD, stallE,
                 flushD, flushE, flushM, div_start, div_busy};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REGW       (5),
    .DIV_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rsD             (rsD),
    .rtD             (rtD),
    .rsE             (rsE),
    .rtE             (rtE),
    .writeregE       (writeregE),
    .writeregM       (writeregM),
    .writeregW       (writeregW),
    .regwriteE       (regwriteE),
    .regwriteM       (regwriteM),
    .regwriteW       (regwriteW),
    .memtoregD       (memtoregD),
    .memtoregE       (memtoregE),
    .memtoregM       (memtoregM),
    .branchD         (branchD),
    .jumprD          (jumprD),
    .rdE             (rdE),
    .rdM             (rdM),
    .cp0writeM       (cp0writeM),
    .divE            (divE),
    .excM            (excM),
    .forwardAE       (forwardAE),
    .forwardBE       (forwardBE),
    .forwardAD       (forwardAD),
    .forwardBD       (forwardBD),
    .forwardcp0dataE (forwardcp0dataE),
    .stallF          (stallF),
    .stallD          (stallD),
    .stallE          (stallE),
    .flushD          (flushD),
    .flushE          (flushE),
    .flushM          (flushM),
    .div_start       (div_start),
    .div_busy        (div_busy)
  );

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregD = 0; memtoregE = 0; memtoregM = 0;
    branchD = 0; jumprD = 0;
    rdE = 0; rdM = 0; cp0writeM = 0;
    divE = 0; excM = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL reset_outs got %b exp %b", outs, O_ZERO);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    rsE = 8; writeregM = 8; regwriteM = 1;
    writeregW = 8; regwriteW = 1;
    #1;
    vec++;
    if (forwardAE !== 2'b10) begin
      errs++;
      $display("FAIL fwdA_m_prio got %b exp 10", forwardAE);
    end
    vec++;
    if (forwardBE !== 2'b00) begin
      errs++;
      $display("FAIL fwdB_reg0 got %b exp 00", forwardBE);
    end
    @(negedge clk);
    regwriteM = 0;
    #1;
    vec++;
    if (forwardAE !== 2'b01) begin
      errs++;
      $display("FAIL fwdA_w got %b exp 01", forwardAE);
    end
    @(negedge clk);
    rsE = 0; regwriteM = 1; writeregM = 0; writeregW = 0;
    #1;
    vec++;
    if (forwardAE !== 2'b00) begin
      errs++;
      $display("FAIL fwdA_reg0 got %b exp 00", forwardAE);
    end
    @(negedge clk);
    clear_inputs();
    rsE = 8; writeregM = 24; regwriteM = 1;
    #1;
    vec++;
    if (forwardAE !== 2'b00) begin
      errs++;
      $display("FAIL fwdA_fullwidth got %b exp 00", forwardAE);
    end
    @(negedge clk);
    clear_inputs();
    rtE = 3; writeregW = 3; regwriteW = 1;
    rsD = 8; writeregM = 8; regwriteM = 1;
    #1;
    vec++;
    if (forwardBE !== 2'b01) begin
      errs++;
      $display("FAIL fwdB_w got %b exp 01", forwardBE);
    end
    vec++;
    if ({forwardAD, forwardBD} !== 2'b10) begin
      errs++;
      $display("FAIL fwd_dstage got %b exp 10",
               {forwardAD, forwardBD});
    end
    @(negedge clk);
    clear_inputs();
    regwriteM = 1;
    #1;
    vec++;
    if ({forwardAD, forwardBD} !== 2'b00) begin
      errs++;
      $display("FAIL fwd_dstage_reg0 got %b exp 00",
               {forwardAD, forwardBD});
    end
  endtask

  task automatic test_cp0();
    logic [4:0] re [4] = '{5'd12, 5'd13, 5'd0, 5'd12};
    logic [4:0] rm [4] = '{5'd12, 5'd12, 5'd0, 5'd12};
    logic       wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      rdE = re[i]; rdM = rm[i]; cp0writeM = wr[i];
      #1;
      vec++;
      if (forwardcp0dataE !== ex[i]) begin
        errs++;
        $display("FAIL cp0_fwd[%0d] got %b exp %b",
                 i, forwardcp0dataE, ex[i]);
      end
    end
  endtask

  task automatic test_loaduse();
    @(negedge clk);
    clear_inputs();
    memtoregE = 1; rtE = 9; rsD = 9;
    #1;
    vec++;
    if (outs !== O_LWST) begin
      errs++;
      $display("FAIL lwstall got %b exp %b", outs, O_LWST);
    end
    @(negedge clk);
    memtoregE = 0;
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL lwstall_release got %b exp %b", outs, O_ZERO);
    end
    @(negedge clk);
    memtoregE = 1; memtoregD = 1;
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL lwstall_ld_in_d got %b exp %b", outs, O_ZERO);
    end
    @(negedge clk);
    clear_inputs();
    memtoregE = 1;
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL lwstall_reg0 got %b exp %b", outs, O_ZERO);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    memtoregM = 1; writeregM = 9; branchD = 1; rtD = 9;
    #1;
    vec++;
    if ({stallF, stallD, stallE, flushE} !== 4'b1101) begin
      errs++;
      $display("FAIL brstall_load_m got %b exp 1101",
               {stallF, stallD, stallE, flushE});
    end
    @(negedge clk);
    memtoregM = 0; regwriteM = 1;
    #1;
    vec++;
    if ({stallF, flushE, forwardBD} !== 3'b001) begin
      errs++;
      $display("FAIL br_alu_m_fwd got %b exp 001",
               {stallF, flushE, forwardBD});
    end
    @(negedge clk);
    clear_inputs();
    jumprD = 1; rsD = 9; regwriteE = 1; writeregE = 9;
    #1;
    vec++;
    if ({stallF, stallD, flushE} !== 3'b111) begin
      errs++;
      $display("FAIL jrstall_e got %b exp 111",
               {stallF, stallD, flushE});
    end
    @(negedge clk);
    rsD = 0; writeregE = 0;
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL jrstall_reg0 got %b exp %b", outs, O_ZERO);
    end
  endtask

  task automatic test_div();
    logic [14:0] ex [6] = '{O_LNCH, O_BUSY, O_BUSY,
                            O_BUSY, O_ZERO, O_ZERO};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      divE = (i < 5);
      if (i == 2) begin
        memtoregE = 1; rtE = 9; rsD = 9;
      end
      #1;
      vec++;
      if (outs !== ex[i]) begin
        errs++;
        $display("FAIL div_seq[%0d] got %b exp %b", i, outs, ex[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [14:0] ex [4] = '{O_LNCH, O_BUSY, O_EXCB, O_ZERO};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      divE = (i < 3);
      excM = (i == 2);
      #1;
      vec++;
      if (outs !== ex[i]) begin
        errs++;
        $display("FAIL div_abort[%0d] got %b exp %b", i, outs, ex[i]);
      end
    end
  endtask

  task automatic test_rst_busy();
    logic [14:0] ex [9] = '{O_LNCH, O_BUSY, O_ZERO, O_LNCH, O_BUSY,
                            O_BUSY, O_BUSY, O_ZERO, O_ZERO};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      divE = (i < 2) || (i >= 3 && i < 8);
      #1;
      vec++;
      if (outs !== ex[i]) begin
        errs++;
        $display("FAIL div_rst[%0d] got %b exp %b", i, outs, ex[i]);
      end
      if (i == 1) rst = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] ex [11] = '{O_LNCH, O_BUSY, O_BUSY, O_BUSY, O_ZERO,
                             O_LNCH, O_BUSY, O_BUSY, O_BUSY, O_ZERO,
                             O_ZERO};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clear_inputs();
      divE = (i < 10);
      #1;
      vec++;
      if (outs !== ex[i]) begin
        errs++;
        $display("FAIL div_b2b[%0d] got %b exp %b", i, outs, ex[i]);
      end
    end
  endtask

  task automatic test_exc_no_launch();
    @(negedge clk);
    clear_inputs();
    divE = 1; excM = 1;
    #1;
    vec++;
    if (outs !== O_EXC) begin
      errs++;
      $display("FAIL exc_idle got %b exp %b", outs, O_EXC);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    vec++;
    if (outs !== O_ZERO) begin
      errs++;
      $display("FAIL exc_no_busy got %b exp %b", outs, O_ZERO);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_cp0();
    test_loaduse();
    test_branch();
    test_div();
    test_abort();
    test_rst_busy();
    test_back_to_back();
    test_exc_no_launch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W), successor to the single-cycle-ALU hazard unit. It resolves register and CP0 forwarding, load-use and branch/jr interlocks, and exception flushes. It also sequences a multi-cycle divider in E through a registered busy counter, so the pipeline stalls for exactly the divide latency. It sits beside the datapath and drives every stage's stall/flush enables.

## Interface
- `REGW`, 5, register-number width
- `DIV_CYCLES`, 32, divider latency in cycles (≥2)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `rsD, rtD, rsE, rtE`  in  REGW  source register numbers in D and E
- `writeregE, writeregM, writeregW`  in  REGW  destination register per stage
- `regwriteE, regwriteM, regwriteW`  in  1  destination write enable per stage
- `memtoregD, memtoregE, memtoregM`  in  1  stage holds a load
- `branchD, jumprD`  in  1  branch / jr-jalr in D
- `rdE, rdM`  in  5  CP0 register number in E / M
- `cp0writeM`  in  1  mtc0 in M
- `divE`  in  1  div/divu in E
- `excM`  in  1  exception taken in M
- `forwardAE, forwardBE`  out  2  E operand select: 00 RF, 01 from W, 10 from M
- `forwardAD, forwardBD`  out  1  D comparator operand from M
- `forwardcp0dataE`  out  1  forward M's mtc0 data to mfc0 in E
- `stallF, stallD, stallE`  out  1  hold stage register
- `flushD, flushE, flushM`  out  1  insert bubble into stage register
- `div_start`  out  1  one-cycle divider launch pulse
- `div_busy`  out  1  divider running

## Operation
- Reg 0 never forwards and never causes a stall. All comparisons use the full REGW width.
- forwardAE/BE: M match has priority over W match. Each requires the matching regwrite.
- forwardAD/BD: `rsD/rtD == writeregM`, regwriteM, nonzero.
- forwardcp0dataE = cp0writeM & (rdE == rdM). CP0 reg 0 is legal.
- lwstall = memtoregE & ~memtoregD & rtE≠0 & (rsD == rtE | rtD == rtE).
- brstall = (branchD | jumprD) & [(regwriteE & writeregE≠0 & writeregE ∈ {rsD, rtD}) | (memtoregM & writeregM≠0 & writeregM ∈ {rsD, rtD})].
  - An ALU result in M is forwarded, not stalled.
- Divider FSM states:
  - IDLE: on divE & ~excM, assert div_start, load cnt = DIV_CYCLES−1, go BUSY.
  - BUSY: decrement cnt each cycle. At cnt == 0 go DONE. excM goes IDLE (abort).
  - DONE: one cycle, no stall. Always goes IDLE. DONE never re-launches, even though divE is still high.
- Stall/flush priority, highest first:
  1. excM: flushD = flushE = flushM = 1, all stalls 0.
  2. Divider in IDLE-with-launch or BUSY: stallF = stallD = stallE = 1, flushM = 1.
  3. lwstall | brstall: stallF = stallD = 1, flushE = 1.
  4. Otherwise all 0.
- div_busy = launch cycle or BUSY.

## Timing
- Only the FSM state and cnt (width clog2(DIV_CYCLES)) are registered. All other outputs are combinational from inputs and state, with no added latency.
- Reset: state IDLE, cnt 0. Consequently, with all inputs 0, every output is 0.
- Divide occupies E for DIV_CYCLES+1 cycles:
  - 1 launch cycle
  - DIV_CYCLES−1 BUSY cycles
  - 1 DONE cycle in which the result is captured and the instruction advances
- Back-to-back divs: the second launches in the cycle after DONE.
- rst in BUSY: IDLE next edge, no div_start.
- excM with divE in IDLE: no launch.
- Reset overrides everything.

## Structure
- Shared package `hazard_pkg`:
  - forward encodings FWD_RF/FWD_W/FWD_M
  - divider state enum IDLE/BUSY/DONE
- Sub-module `hazard_div_fsm`: FSM + counter. Outputs div_start, div_busy, div_stall.
- Top: forwarding/interlock logic and priority mux.

## Test plan
- Forwarding, with rsE = 8, writeregM = 8, regwriteM = 1 and writeregW = 8, regwriteW = 1: forwardAE = 10. Dropping regwriteM gives 01. With rsE = 0, forwardAE = 00.
- Load-use: memtoregE = 1, rtE = 9, rsD = 9 → stallF = stallD = flushE = 1 for one cycle. Also memtoregM = 1, writeregM = 9, branchD = 1, rtD = 9 → brstall.
- Divider, DIV_CYCLES = 4, divE held high:
  - div_start is a one-cycle pulse.
  - stallE and flushM are high for 4 cycles, then low in DONE.
  - There is no second div_start.
- Abort: excM asserted on the 2nd BUSY cycle → flushD/E/M = 1 that cycle, stalls 0, div_busy = 0 next cycle.
- Reset: rst during BUSY → all outputs 0 next cycle. A fresh divE afterwards launches normally.
- CP0: cp0writeM = 1, rdM = rdE = 12 → forwardcp0dataE = 1. With rdE = 13 → 0.
